// File: rtl/if_id_fifo_pkg.sv
// Shared pipeline constants (instruction NOP, zero word, interrupt default, hold levels) and
// the hold-level decode used by the IF/ID buffer.
`ifndef IF_ID_DEFINES_SVH
`define IF_ID_DEFINES_SVH
`define INST_NOP      32'h00000001
`define ZeroWord      32'h00000000
`define INT_NONE      8'h00
`define Hold_Flag_Bus 2:0
`define Hold_None     3'b000
`define Hold_Pc       3'b001
`define Hold_If       3'b010
`define Hold_Id       3'b011
`define InstBus       31:0
`define InstAddrBus   31:0
`define INT_BUS       7:0
`endif

package if_id_fifo_pkg;
    localparam int HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_IF   = `Hold_If;
    localparam logic [31:0]       INST_NOP  = `INST_NOP;
    localparam logic [31:0]       ZERO_WORD = `ZeroWord;
    localparam logic [7:0]        INT_NONE  = `INT_NONE;

    // Any hold at or beyond the IF stage freezes the buffer head.
    function automatic logic hold_active(input logic [HOLD_W-1:0] hold_flag);
        return hold_flag >= HOLD_IF;
    endfunction
endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x W storage for the IF/ID buffer: one synchronous write port, one asynchronous read port.
// No reset on the array; validity is tracked by the control logic in the top module.
module if_id_fifo_mem #(
    parameter int W     = 72,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [W-1:0]     i_wr_dat,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [W-1:0]     o_rd_dat
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];
endmodule

// File: rtl/if_id_fifo.sv
// Fetch-to-decode FIFO: 1-cycle push-to-head latency, strict order, in_ready drops when full or flushing,
// head frozen while hold >= IF. IF_ID_BYPASS_EN adds a combinational empty-buffer pass-through.
module if_id_fifo
    import if_id_fifo_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int INT_W  = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [INT_W-1:0]  int_flag_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [INT_W-1:0]  int_flag_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INST_W + ADDR_W + INT_W;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_hold_en;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_rd_adv;
    logic [ENT_W-1:0] w_wr_ent;
    logic [ENT_W-1:0] w_rd_ent;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_hold_en  = hold_active(hold_flag_i);
    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign in_ready_o = ~w_full & ~flush_i;
    assign w_push     = in_valid_i & in_ready_o;
    assign w_pop      = out_valid_o & out_ready_i & ~w_hold_en;
    assign w_wr_ent   = {inst_i, inst_addr_i, int_flag_i};
    assign count_o    = r_count;

`ifdef IF_ID_BYPASS_EN
    logic w_bypass;

    assign w_bypass = w_empty & in_valid_i & ~flush_i;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_wr_en  = w_push & ~(w_bypass & w_pop);
    assign w_rd_adv = w_pop & ~w_bypass;

    always_comb begin
        out_valid_o = (~w_empty | w_bypass) & ~flush_i;
        inst_o      = INST_W'(INST_NOP);
        inst_addr_o = ADDR_W'(ZERO_WORD);
        int_flag_o  = INT_W'(INT_NONE);
        if (w_bypass) begin
            {inst_o, inst_addr_o, int_flag_o} = w_wr_ent;
        end else if (!w_empty) begin
            {inst_o, inst_addr_o, int_flag_o} = w_rd_ent;
        end
    end
`else
    assign w_wr_en  = w_push;
    assign w_rd_adv = w_pop;

    always_comb begin
        out_valid_o = ~w_empty;
        inst_o      = INST_W'(INST_NOP);
        inst_addr_o = ADDR_W'(ZERO_WORD);
        int_flag_o  = INT_W'(INT_NONE);
        if (!w_empty) begin
            {inst_o, inst_addr_o, int_flag_o} = w_rd_ent;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_adv})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    if_id_fifo_mem #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (w_wr_ent),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_ent)
    );
endmodule

// File: tb/tb_if_id_fifo.sv
// Bench for if_id_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_if_id_fifo;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [7:0]  flag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [7:0]  int_flag_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  hold_flag_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [7:0]  int_flag_o;
    logic [2:0]  count_o;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    if_id_fifo #(
        .INST_W (32),
        .ADDR_W (32),
        .INT_W  (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .int_flag_i  (int_flag_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .hold_flag_i (hold_flag_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .int_flag_o  (int_flag_o),
        .count_o     (count_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: occupancy and order from the buffer rules, no pointers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else if (flush_i) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (in_valid_i) q.push_back({inst_i, inst_addr_i, int_flag_i});
        end else if (q.size() == DEPTH) begin
            if (out_ready_i && hold_flag_i < 3'd2) void'(q.pop_front());
        end else begin
            if (out_ready_i && hold_flag_i < 3'd2) void'(q.pop_front());
            if (in_valid_i) q.push_back({inst_i, inst_addr_i, int_flag_i});
        end
    end

    always @(negedge clk) begin
        chk("m_count", 64'(count_o), 64'(q.size()));
        chk("m_out_valid", 64'(out_valid_o), 64'(q.size() != 0));
        chk("m_in_ready", 64'(in_ready_o), 64'((q.size() != DEPTH) && !flush_i));
        chk("m_inst", 64'(inst_o), (q.size() != 0) ? 64'(q[0].inst) : 64'h1);
        chk("m_addr", 64'(inst_addr_o), (q.size() != 0) ? 64'(q[0].addr) : 64'h0);
        chk("m_flag", 64'(int_flag_o), (q.size() != 0) ? 64'(q[0].flag) : 64'h0);
    end

    // Drive one cycle of inputs just after a rising edge; returns just after the next one.
    task automatic step(input logic v, input logic [31:0] a, input logic [7:0] f,
                        input logic rdy, input logic [2:0] h, input logic fl);
        in_valid_i  = v;
        inst_addr_i = a;
        inst_i      = {16'hC0DE, a[15:0]};
        int_flag_i  = f;
        out_ready_i = rdy;
        hold_flag_i = h;
        flush_i     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        step(1'b1, a, 8'h00, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 8'h00, rdy, 3'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0; int_flag_i = '0;
        out_ready_i = 1'b0; hold_flag_i = '0; flush_i = 1'b0;
        @(posedge clk); #1;
        idle(1'b0);
        rst = 1'b1;
        idle(1'b0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'h00000001);
        chk("rst_addr", 64'(inst_addr_o), 64'h0);

        // Fill, refuse fifth push, drain in order
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i));
        chk("full_count", 64'(count_o), 64'd4);
        chk("full_in_ready", 64'(in_ready_o), 64'd0);
        step(1'b1, 32'h110, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("refused_count", 64'(count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", 64'(inst_addr_o), 64'(32'h100 + 32'(4 * i)));
            idle(1'b1);
        end
        chk("drained_count", 64'(count_o), 64'd0);

        // Simultaneous push and pop at count 2
        push(32'h200);
        push(32'h204);
        step(1'b1, 32'h208, 8'h00, 1'b1, 3'd0, 1'b0);
        chk("pp_count", 64'(count_o), 64'd2);
        chk("pp_head", 64'(inst_addr_o), 64'h204);
        idle(1'b1);
        chk("pp_next", 64'(inst_addr_o), 64'h208);
        idle(1'b1);

        // Hold at ID level freezes the head
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 8'h00, 1'b1, 3'd3, 1'b0);
            chk("hold_addr", 64'(inst_addr_o), 64'h300);
            chk("hold_count", 64'(count_o), 64'd3);
        end
        idle(1'b1);
        chk("release_addr", 64'(inst_addr_o), 64'h304);
        chk("release_count", 64'(count_o), 64'd2);
        idle(1'b1);
        idle(1'b1);

        // Flush wins over push and pop on a full buffer
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i));
        step(1'b1, 32'h410, 8'h00, 1'b1, 3'd0, 1'b1);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        push(32'h500);
        chk("post_flush_valid", 64'(out_valid_o), 64'd1);
        chk("post_flush_addr", 64'(inst_addr_o), 64'h500);
        idle(1'b1);

        // Interrupt flag stays with its own entry
        step(1'b1, 32'h600, 8'h01, 1'b0, 3'd0, 1'b0);
        step(1'b1, 32'h604, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("flag_first", 64'(int_flag_o), 64'h01);
        idle(1'b1);
        chk("flag_second", 64'(int_flag_o), 64'h00);
        chk("flag_second_addr", 64'(inst_addr_o), 64'h604);
        idle(1'b1);

        // Reset mid-operation drops everything
        push(32'h700);
        push(32'h704);
        rst = 1'b0;
        idle(1'b0);
        chk("midrst_count", 64'(count_o), 64'd0);
        rst = 1'b1;
        idle(1'b0);
        chk("midrst_valid", 64'(out_valid_o), 64'd0);

        // Pointer wrap with mixed traffic, checked by the model every cycle
        for (int k = 0; k < 12 * DEPTH; k++) begin
            step(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * k), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 3'd3 : 3'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
